// File: rtl/rc522_spi_burst.sv
// rtl/rc522_spi_burst.sv - MFRC522 SPI burst engine: one address byte plus 1..MAX_LEN data bytes per frame
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   start             one-cycle request, taken only while idle
//   rw, addr, len     direction (1=read), register address, data byte count
//   wdata             write bytes, byte k at wdata[8k-1:8k-8]
//   rdata             read bytes, byte k at rdata[8k-1:8k-8]
//   busy, done, err   transaction in progress, end pulse, invalid-request pulse
//   cs, sck, mosi     SPI mode 0 outputs (cs active low)
//   miso              SPI data in
module rc522_spi_burst #(
  parameter int MAX_LEN = 16,
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 rw,
  input  logic [5:0]           addr,
  input  logic [LEN_W-1:0]     len,
  input  logic [8*MAX_LEN-1:0] wdata,
  output logic [8*MAX_LEN-1:0] rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 cs,
  output logic                 sck,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]           state;
  logic                 pend;      // request latched, acted on one cycle later
  logic                 rw_q;
  logic [5:0]           addr_q;
  logic [LEN_W-1:0]     len_q;
  logic [8*MAX_LEN-1:0] wbuf;      // write bytes, consumed from the low end
  logic [DIV_W-1:0]     div_cnt;
  logic [2:0]           bit_cnt;
  logic [LEN_W-1:0]     byte_cnt;  // frame byte currently on the wire (0 = address)
  logic [7:0]           tx_sr;
  logic [7:0]           rx_sr;
  logic [7:0]           addr_byte;
  logic [7:0]           next_byte;
  logic                 len_bad;
  logic                 div_end;
  logic                 last_bit;

  assign addr_byte = {rw_q, addr_q, 1'b0};
  assign len_bad   = (len_q == '0) || (len_q > LEN_MAX);
  assign div_end   = (div_cnt == DIV_LAST);
  assign last_bit  = (bit_cnt == 3'd7) && (byte_cnt == len_q);

  // Reads keep clocking the address byte so the chip streams the same register,
  // and close the burst with 0x00 on the final byte.
  always_comb begin
    next_byte = wbuf[7:0];
    if (rw_q) begin
      next_byte = ((byte_cnt + LEN_W'(1)) == len_q) ? 8'h00 : addr_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pend     <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      wbuf     <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cs       <= 1'b1;
      sck      <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          if (pend) begin
            pend <= 1'b0;
            if (len_bad) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              cs       <= 1'b0;
              busy     <= 1'b1;
              tx_sr    <= addr_byte;
              mosi     <= addr_byte[7];
              bit_cnt  <= '0;
              byte_cnt <= '0;
              state    <= S_SETUP;
              if (rw_q) begin
                rdata <= '0;
              end
            end
          end else if (start) begin
            pend   <= 1'b1;
            rw_q   <= rw;
            addr_q <= addr;
            len_q  <= len;
            wbuf   <= wdata;
          end
        end

        S_SETUP: begin
          if (div_end) begin
            div_cnt <= '0;
            mosi    <= tx_sr[7];
            state   <= S_SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_SHIFT: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!sck) begin
              sck   <= 1'b1;
              rx_sr <= {rx_sr[6:0], miso};
            end else begin
              sck <= 1'b0;
              // Falling edge closes a bit; at a byte boundary rx_sr is complete.
              if (rw_q && (bit_cnt == 3'd7)) begin
                for (int k = 1; k <= MAX_LEN; k++) begin
                  if (byte_cnt == LEN_W'(k)) begin
                    rdata[8*k-8 +: 8] <= rx_sr;
                  end
                end
              end
              if (last_bit) begin
                mosi  <= 1'b0;
                state <= S_HOLD;
              end else if (bit_cnt == 3'd7) begin
                bit_cnt  <= '0;
                byte_cnt <= byte_cnt + LEN_W'(1);
                tx_sr    <= next_byte;
                mosi     <= next_byte[7];
                if (!rw_q) begin
                  wbuf <= wbuf >> 8;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                tx_sr   <= {tx_sr[6:0], 1'b0};
                mosi    <= tx_sr[6];
              end
            end
          end
        end

        S_HOLD: begin
          if (div_end) begin
            div_cnt <= '0;
            cs      <= 1'b1;
            done    <= 1'b1;
            state   <= S_GAP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (div_end) begin
            div_cnt <= '0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc522_spi_burst.sv
// tb/tb_rc522_spi_burst.sv - randomized self-checking bench for rc522_spi_burst (D=2 and D=1 instances)
module tb_rc522_spi_burst;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int NB      = 8 * MAX_LEN;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          rw    = 1'b0;
  logic [5:0]    addr  = '0;
  logic [LEN_W-1:0] len = '0;
  logic [NB-1:0] wdata = '0;
  logic          sel   = 1'b0;   // 0: D=2 instance, 1: D=1 instance
  logic          miso;

  logic [NB-1:0] rdata0, rdata1, rdata_m;
  logic busy0, busy1, done0, done1, err0, err1, cs0, cs1, sck0, sck1, mosi0, mosi1;
  logic busy_m, done_m, err_m, cs_m, sck_m, mosi_m;

  int errors = 0;
  int checks = 0;

  logic [NB-1:0] exp_rd [0:1];
  logic [7:0]    resp [0:MAX_LEN];
  logic          miso_bits [0:1023];
  logic          mosi_hist [0:1023];
  int            nrise = 0;
  int            rise_base = 0;
  int            cs_low_tot = 0, done_tot = 0, err_tot = 0, busy_tot = 0;

  int            o_lat, o_rise, o_cslow, o_done, o_err, o_busy;
  logic          o_err_at_done;
  logic [7:0]    o_mosi [0:MAX_LEN];

  always #5 clk = ~clk;

  rc522_spi_burst #(.MAX_LEN(MAX_LEN), .CLK_DIV(2), .LEN_W(LEN_W)) u_d2 (
    .clk(clk), .rst(rst), .start(start && !sel), .rw(rw), .addr(addr), .len(len),
    .wdata(wdata), .rdata(rdata0), .busy(busy0), .done(done0), .err(err0),
    .cs(cs0), .sck(sck0), .mosi(mosi0), .miso(miso)
  );

  rc522_spi_burst #(.MAX_LEN(MAX_LEN), .CLK_DIV(1), .LEN_W(LEN_W)) u_d1 (
    .clk(clk), .rst(rst), .start(start && sel), .rw(rw), .addr(addr), .len(len),
    .wdata(wdata), .rdata(rdata1), .busy(busy1), .done(done1), .err(err1),
    .cs(cs1), .sck(sck1), .mosi(mosi1), .miso(miso)
  );

  assign rdata_m = sel ? rdata1 : rdata0;
  assign busy_m  = sel ? busy1  : busy0;
  assign done_m  = sel ? done1  : done0;
  assign err_m   = sel ? err1   : err0;
  assign cs_m    = sel ? cs1    : cs0;
  assign sck_m   = sel ? sck1   : sck0;
  assign mosi_m  = sel ? mosi1  : mosi0;

  // Slave model: the n-th sck rise of the frame sees bit n of the response stream.
  assign miso = miso_bits[10'(nrise - rise_base)];

  always @(posedge sck_m) begin
    mosi_hist[nrise[9:0]] <= mosi_m;
    nrise <= nrise + 1;
  end

  always @(negedge clk) begin
    if (cs_m === 1'b0) cs_low_tot <= cs_low_tot + 1;
    if (done_m === 1'b1) done_tot <= done_tot + 1;
    if (err_m === 1'b1) err_tot <= err_tot + 1;
    if (busy_m === 1'b1) busy_tot <= busy_tot + 1;
  end

  function automatic logic [7:0] model_mosi(logic m_rw, logic [5:0] m_addr, int m_len,
                                            logic [NB-1:0] m_wd, int j);
    logic [7:0] a;
    a = {m_rw, m_addr, 1'b0};
    if (j == 0) return a;
    if (!m_rw) return m_wd[8*j-8 +: 8];
    return (j == m_len) ? 8'h00 : a;
  endfunction

  function automatic logic [NB-1:0] model_rdata(int m_len);
    logic [NB-1:0] r;
    r = '0;
    for (int k = 1; k <= m_len; k++) r[8*k-8 +: 8] = resp[k];
    return r;
  endfunction

  function automatic logic [NB-1:0] rand_wd();
    logic [NB-1:0] w;
    for (int i = 0; i < NB / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  task automatic run_txn(input logic t_rw, input logic [5:0] t_addr, input int t_len,
                         input logic [NB-1:0] t_wd, input int inject_at, input int abort_at);
    int b_rise, b_cs, b_done, b_err, b_busy;
    @(posedge clk); #1;
    rw = t_rw; addr = t_addr; len = LEN_W'(t_len); wdata = t_wd;
    for (int j = 0; j <= MAX_LEN; j++)
      for (int b = 0; b < 8; b++) miso_bits[8*j+b] = resp[j][7-b];
    rise_base = nrise;
    b_rise = nrise; b_cs = cs_low_tot; b_done = done_tot; b_err = err_tot; b_busy = busy_tot;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    o_lat = -1;
    o_err_at_done = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk); #1;
      if (n == abort_at) return;
      if (n == inject_at) begin addr = ~t_addr; start = 1'b1; end
      if (n == inject_at + 1) start = 1'b0;
      if (done_m === 1'b1) begin o_lat = n; o_err_at_done = err_m; break; end
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    o_rise = nrise - b_rise; o_cslow = cs_low_tot - b_cs; o_done = done_tot - b_done;
    o_err = err_tot - b_err; o_busy = busy_tot - b_busy;
    for (int j = 0; j <= MAX_LEN; j++)
      for (int b = 0; b < 8; b++) o_mosi[j][7-b] = mosi_hist[10'(b_rise + 8*j + b)];
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++; if ({cs0, sck0, mosi0, busy0, done0, err0} !== 6'b100000)
      $display("FAIL reset_ctl_d2: got %b want 100000", {cs0, sck0, mosi0, busy0, done0, err0});
    checks++; if (rdata0 !== '0) $display("FAIL reset_rdata_d2: got %h want 0", rdata0);
    checks++; if ({cs1, sck1, mosi1, busy1, done1, err1} !== 6'b100000)
      $display("FAIL reset_ctl_d1: got %b want 100000", {cs1, sck1, mosi1, busy1, done1, err1});
    checks++; if (rdata1 !== '0) $display("FAIL reset_rdata_d1: got %h want 0", rdata1);
    errors += int'({cs0, sck0, mosi0, busy0, done0, err0} !== 6'b100000) + int'(rdata0 !== '0)
            + int'({cs1, sck1, mosi1, busy1, done1, err1} !== 6'b100000) + int'(rdata1 !== '0);
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if ({cs_m, sck_m, busy_m, done_m} !== 4'b1000) begin
      errors++; $display("FAIL idle_after_reset: got %b want 1000", {cs_m, sck_m, busy_m, done_m});
    end
    exp_rd[0] = '0; exp_rd[1] = '0;
  endtask

  task automatic test_write_single;
    logic [NB-1:0] wd;
    sel = 1'b0;
    for (int j = 0; j <= MAX_LEN; j++) resp[j] = 8'($urandom);
    wd = '0; wd[7:0] = 8'h0F;
    run_txn(1'b0, 6'h01, 1, wd, 0, 0);
    checks++; if (o_mosi[0] !== 8'h02) begin errors++; $display("FAIL wr_mosi0: got %h want 02", o_mosi[0]); end
    checks++; if (o_mosi[1] !== 8'h0F) begin errors++; $display("FAIL wr_mosi1: got %h want 0f", o_mosi[1]); end
    checks++; if (o_rise != 16) begin errors++; $display("FAIL wr_rises: got %0d want 16", o_rise); end
    checks++; if (o_cslow != 68) begin errors++; $display("FAIL wr_cs_low: got %0d want 68", o_cslow); end
    checks++; if (o_lat != 69) begin errors++; $display("FAIL wr_latency: got %0d want 69", o_lat); end
    checks++; if (o_done != 1 || o_err != 0) begin
      errors++; $display("FAIL wr_done_err: got done=%0d err=%0d want 1 0", o_done, o_err);
    end
    checks++; if (rdata_m !== exp_rd[0]) begin errors++; $display("FAIL wr_rdata_kept: got %h want %h", rdata_m, exp_rd[0]); end
  endtask

  task automatic test_read_fifo;
    sel = 1'b0;
    for (int j = 0; j <= MAX_LEN; j++) resp[j] = 8'($urandom);
    resp[1] = 8'hAB; resp[2] = 8'hCD; resp[3] = 8'hEF; resp[4] = 8'h12;
    run_txn(1'b1, 6'h09, 4, rand_wd(), 0, 0);
    for (int j = 0; j <= 4; j++) begin
      checks++; if (o_mosi[j] !== model_mosi(1'b1, 6'h09, 4, '0, j)) begin
        errors++; $display("FAIL rd_mosi%0d: got %h want %h", j, o_mosi[j], model_mosi(1'b1, 6'h09, 4, '0, j));
      end
    end
    checks++; if (rdata_m[31:0] !== 32'h12EFCDAB) begin errors++; $display("FAIL rd_low: got %h want 12efcdab", rdata_m[31:0]); end
    checks++; if (rdata_m[NB-1:32] !== '0) begin errors++; $display("FAIL rd_upper: got %h want 0", rdata_m[NB-1:32]); end
    checks++; if (o_lat != 165 || o_cslow != 164) begin
      errors++; $display("FAIL rd_timing: got lat=%0d cs=%0d want 165 164", o_lat, o_cslow);
    end
    exp_rd[0] = model_rdata(4);
  endtask

  task automatic test_invalid_len;
    int bad [0:1];
    sel = 1'b0;
    bad[0] = 0; bad[1] = MAX_LEN + 1;
    for (int i = 0; i < 2; i++) begin
      run_txn(1'($urandom), 6'($urandom), bad[i], rand_wd(), 0, 0);
      checks++; if (o_lat != 1 || o_err_at_done !== 1'b1) begin
        errors++; $display("FAIL bad_len%0d_pulse: got lat=%0d err=%b want 1 1", bad[i], o_lat, o_err_at_done);
      end
      checks++; if (o_done != 1 || o_err != 1) begin
        errors++; $display("FAIL bad_len%0d_width: got done=%0d err=%0d want 1 1", bad[i], o_done, o_err);
      end
      checks++; if (o_cslow != 0 || o_busy != 0 || o_rise != 0) begin
        errors++; $display("FAIL bad_len%0d_quiet: got cs=%0d busy=%0d rise=%0d want 0 0 0", bad[i], o_cslow, o_busy, o_rise);
      end
      checks++; if (rdata_m !== exp_rd[0]) begin errors++; $display("FAIL bad_len%0d_rdata: got %h want %h", bad[i], rdata_m, exp_rd[0]); end
    end
  endtask

  task automatic test_start_ignored;
    logic [NB-1:0] wd;
    sel = 1'b0;
    wd = rand_wd();
    run_txn(1'b0, 6'h15, 2, wd, 40, 0);
    for (int j = 0; j <= 2; j++) begin
      checks++; if (o_mosi[j] !== model_mosi(1'b0, 6'h15, 2, wd, j)) begin
        errors++; $display("FAIL busy_mosi%0d: got %h want %h", j, o_mosi[j], model_mosi(1'b0, 6'h15, 2, wd, j));
      end
    end
    checks++; if (o_done != 1 || o_lat != 101) begin
      errors++; $display("FAIL busy_done: got done=%0d lat=%0d want 1 101", o_done, o_lat);
    end
    checks++; if (o_cslow != 100 || o_rise != 24) begin
      errors++; $display("FAIL busy_frame: got cs=%0d rise=%0d want 100 24", o_cslow, o_rise);
    end
  endtask

  task automatic test_reset_mid;
    int b_done;
    logic [5:0] a;
    sel = 1'b0;
    for (int j = 0; j <= MAX_LEN; j++) resp[j] = 8'($urandom);
    b_done = done_tot;
    run_txn(1'b1, 6'h09, 4, '0, 0, 45);
    checks++; if (cs_m !== 1'b0 || sck_m !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got cs=%b sck=%b want 0 1", cs_m, sck_m);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (cs_m !== 1'b1 || sck_m !== 1'b0 || busy_m !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got cs=%b sck=%b busy=%b want 1 0 0", cs_m, sck_m, busy_m);
    end
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    checks++; if (done_tot != b_done) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_tot - b_done); end
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int j = 0; j <= MAX_LEN; j++) resp[j] = 8'($urandom);
    a = 6'($urandom);
    run_txn(1'b1, a, 1, '0, 0, 0);
    exp_rd[0] = model_rdata(1);
    checks++; if (rdata_m !== exp_rd[0]) begin errors++; $display("FAIL rstmid_rdata: got %h want %h", rdata_m, exp_rd[0]); end
    checks++; if (o_mosi[0] !== {1'b1, a, 1'b0} || o_mosi[1] !== 8'h00) begin
      errors++; $display("FAIL rstmid_mosi: got %h %h want %h 00", o_mosi[0], o_mosi[1], {1'b1, a, 1'b0});
    end
    checks++; if (o_lat != 69 || o_done != 1) begin
      errors++; $display("FAIL rstmid_done: got lat=%0d done=%0d want 69 1", o_lat, o_done);
    end
  endtask

  task automatic test_max_len_d1;
    logic [5:0] a;
    sel = 1'b1;
    resp[0] = 8'($urandom);
    for (int k = 1; k <= MAX_LEN; k++) resp[k] = 8'(k);
    a = 6'($urandom);
    run_txn(1'b1, a, MAX_LEN, rand_wd(), 0, 0);
    for (int k = 1; k <= MAX_LEN; k++) begin
      checks++; if (rdata_m[8*k-8 +: 8] !== 8'(k)) begin
        errors++; $display("FAIL max_rdata%0d: got %h want %h", k, rdata_m[8*k-8 +: 8], 8'(k));
      end
    end
    checks++; if (o_cslow != 274 || o_lat != 275) begin
      errors++; $display("FAIL max_timing: got cs=%0d lat=%0d want 274 275", o_cslow, o_lat);
    end
    checks++; if (o_rise != 136 || o_busy != 275) begin
      errors++; $display("FAIL max_frame: got rise=%0d busy=%0d want 136 275", o_rise, o_busy);
    end
    exp_rd[1] = model_rdata(MAX_LEN);
  endtask

  task automatic test_random;
    logic t_rw;
    logic [5:0] t_addr;
    logic [NB-1:0] t_wd;
    int t_len, d, k;
    for (int it = 0; it < 8; it++) begin
      sel = 1'($urandom_range(0, 1));
      d = sel ? 1 : 2;
      t_rw = 1'($urandom); t_addr = 6'($urandom); t_len = $urandom_range(1, MAX_LEN);
      t_wd = rand_wd();
      for (int j = 0; j <= MAX_LEN; j++) resp[j] = 8'($urandom);
      run_txn(t_rw, t_addr, t_len, t_wd, 0, 0);
      if (t_rw) exp_rd[sel] = model_rdata(t_len);
      k = 16 * t_len + 18;
      checks++; if (o_lat != d * k + 1 || o_cslow != d * k || o_busy != d * (k + 1)) begin
        errors++; $display("FAIL rnd%0d_timing: got lat=%0d cs=%0d busy=%0d want %0d %0d %0d",
                           it, o_lat, o_cslow, o_busy, d * k + 1, d * k, d * (k + 1));
      end
      checks++; if (o_rise != 8 * (t_len + 1) || o_done != 1 || o_err != 0) begin
        errors++; $display("FAIL rnd%0d_frame: got rise=%0d done=%0d err=%0d want %0d 1 0",
                           it, o_rise, o_done, o_err, 8 * (t_len + 1));
      end
      for (int j = 0; j <= t_len; j++) begin
        checks++; if (o_mosi[j] !== model_mosi(t_rw, t_addr, t_len, t_wd, j)) begin
          errors++; $display("FAIL rnd%0d_mosi%0d: got %h want %h", it, j, o_mosi[j], model_mosi(t_rw, t_addr, t_len, t_wd, j));
        end
      end
      checks++; if (rdata_m !== exp_rd[sel]) begin
        errors++; $display("FAIL rnd%0d_rdata: got %h want %h", it, rdata_m, exp_rd[sel]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin miso_bits[i] = 1'b0; mosi_hist[i] = 1'b0; end
    for (int j = 0; j <= MAX_LEN; j++) resp[j] = 8'h00;
    exp_rd[0] = '0; exp_rd[1] = '0;
    test_reset;
    test_write_single;
    test_read_fifo;
    test_invalid_len;
    test_start_ignored;
    test_reset_mid;
    test_max_len_d1;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
